vga_timing_monitor: RTL and testbench

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_timing_monitor.sv | 157 +++++++++++++++
 tb/tb_vga_timing_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: recovers pixel position from a VGA stream, checks timing, locks and checksums frames
// Inputs : clk, rst (async, active high), vga_clk (pixel clock sampled as data),
//          hsync/vsync (active low), blank_n, rgb {R,G,B}, err_clr
// Outputs: x_pos/y_pos/pixel_rgb qualified by pixel_valid, locked, frame_done pulse,
//          frame_count, frame_sum, sticky err_flags {blank, frame length, line length}
module vga_timing_monitor #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_clk,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [23:0] rgb,
  input  logic        err_clr,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        pixel_valid,
  output logic [23:0] pixel_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [31:0] frame_sum,
  output logic [2:0]  err_flags
);
  localparam logic [9:0]  H_ST  = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  H_END = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_ST  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] H_LEN = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN = 11'(V_TOTAL);
  typedef enum logic [1:0] {UNLOCKED, SEEK, LOCKED} state_t;
  state_t      state_q, state_d;
  logic        vga_prev_q, tick_q, hs_q, hs_prev_q, vs_q, vs_prev_q, bl_q;
  logic        hs_d, hs_prev_d, vs_d, vs_prev_d, bl_d, tick;
  logic [23:0] rgb_q, rgb_d, pixel_rgb_q, pixel_rgb_d;
  logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d, seek_q, seek_d;
  logic [9:0]  h_cnt_q, h_cnt_d, line_cnt_q, line_cnt_d, h_next, line_next;
  logic [9:0]  x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [31:0] acc_q, acc_d, frame_sum_q, frame_sum_d, add, sum_now;
  logic [15:0] frame_count_q, frame_count_d;
  logic [2:0]  err_q, err_d, new_err;
  logic        h_fall, v_fall, active, pv, fdone, pv_q, fdone_q;
  always_comb begin
    tick        = vga_clk & ~vga_prev_q;
    hs_d        = tick ? hsync : hs_q;
    hs_prev_d   = tick ? hs_q : hs_prev_q;
    vs_d        = tick ? vsync : vs_q;
    vs_prev_d   = tick ? vs_q : vs_prev_q;
    bl_d        = tick ? blank_n : bl_q;
    rgb_d       = tick ? rgb : rgb_q;
    // sampled values land one clk after the tick; counting happens on that delayed tick
    h_fall      = tick_q & hs_prev_q & ~hs_q;
    v_fall      = tick_q & vs_prev_q & ~vs_q;
    h_next      = h_fall ? 10'd0 : (&h_cnt_q ? h_cnt_q : h_cnt_q + 10'd1);
    line_next   = v_fall ? 10'd0 : ((h_fall && !(&line_cnt_q)) ? line_cnt_q + 10'd1 : line_cnt_q);
    active      = (h_next >= H_ST) && (h_next < H_END) && (line_next >= V_ST) && (line_next < V_END);
    new_err[0]  = h_fall & h_seen_q & (({1'b0, h_cnt_q} + 11'd1) != H_LEN);
    new_err[1]  = v_fall & v_seen_q & (({1'b0, line_cnt_q} + {10'd0, h_fall}) != V_LEN);
    new_err[2]  = tick_q & (state_q == LOCKED) & (bl_q != active);
    pv          = tick_q & (state_q == LOCKED) & bl_q;
    fdone       = v_fall & (state_q == LOCKED);
    h_cnt_d     = tick_q ? h_next : h_cnt_q;
    line_cnt_d  = tick_q ? line_next : line_cnt_q;
    h_seen_d    = h_seen_q | h_fall;
    v_seen_d    = v_seen_q | v_fall;
    add         = pv ? 32'(rgb_q[23:16]) + 32'(rgb_q[15:8]) + 32'(rgb_q[7:0]) : 32'd0;
    sum_now     = acc_q + add;
    acc_d       = fdone ? 32'd0 : sum_now;
    frame_sum_d = fdone ? sum_now : frame_sum_q;
    frame_count_d = frame_count_q + {15'd0, fdone};
    x_pos_d     = pv ? h_next - H_ST : x_pos_q;
    y_pos_d     = pv ? line_next - V_ST : y_pos_q;
    pixel_rgb_d = pv ? rgb_q : pixel_rgb_q;
    // a fresh error beats a simultaneous clear
    err_d       = (err_clr ? 3'd0 : err_q) | new_err;
    state_d     = state_q;
    seek_d      = seek_q;
    if (state_q == UNLOCKED) begin
      state_d = v_fall ? SEEK : UNLOCKED;
      seek_d  = 1'b0;
    end else if (|new_err) begin
      state_d = UNLOCKED;
    end else if (state_q == SEEK && v_fall) begin
      state_d = seek_q ? LOCKED : SEEK;
      seek_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= UNLOCKED;
      vga_prev_q    <= 1'b0;
      tick_q        <= 1'b0;
      hs_q          <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_q          <= 1'b0;
      vs_prev_q     <= 1'b0;
      bl_q          <= 1'b0;
      rgb_q         <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      seek_q        <= 1'b0;
      h_cnt_q       <= '0;
      line_cnt_q    <= '0;
      acc_q         <= '0;
      frame_sum_q   <= '0;
      frame_count_q <= '0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      pixel_rgb_q   <= '0;
      err_q         <= '0;
      pv_q          <= 1'b0;
      fdone_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      vga_prev_q    <= vga_clk;
      tick_q        <= tick;
      hs_q          <= hs_d;
      hs_prev_q     <= hs_prev_d;
      vs_q          <= vs_d;
      vs_prev_q     <= vs_prev_d;
      bl_q          <= bl_d;
      rgb_q         <= rgb_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      seek_q        <= seek_d;
      h_cnt_q       <= h_cnt_d;
      line_cnt_q    <= line_cnt_d;
      acc_q         <= acc_d;
      frame_sum_q   <= frame_sum_d;
      frame_count_q <= frame_count_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      pixel_rgb_q   <= pixel_rgb_d;
      err_q         <= err_d;
      pv_q          <= pv;
      fdone_q       <= fdone;
    end
  end
  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign pixel_valid = pv_q;
  assign pixel_rgb   = pixel_rgb_q;
  assign locked      = (state_q == LOCKED);
  assign frame_done  = fdone_q;
  assign frame_count = frame_count_q;
  assign frame_sum   = frame_sum_q;
  assign err_flags   = err_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: randomized VGA stream against a reference model with a decoupled scoreboard
module tb_vga_timing_monitor;
  localparam int HS = 4, HB = 3, HA = 8, HT = 20;
  localparam int VS = 2, VB = 2, VA = 6, VT = 12;
  logic clk = 0, rst = 1, vga_clk = 0, hsync = 1, vsync = 1, blank_n = 0, err_clr = 0;
  logic [23:0] rgb = '0;
  logic [9:0]  x_pos, y_pos;
  logic        pixel_valid, locked, frame_done;
  logic [23:0] pixel_rgb;
  logic [15:0] frame_count;
  logic [31:0] frame_sum;
  logic [2:0]  err_flags;
  vga_timing_monitor #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync),
    .blank_n(blank_n), .rgb(rgb), .err_clr(err_clr), .x_pos(x_pos), .y_pos(y_pos),
    .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb), .locked(locked),
    .frame_done(frame_done), .frame_count(frame_count), .frame_sum(frame_sum),
    .err_flags(err_flags)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  typedef struct { int x; int y; logic [23:0] c; } pix_t;
  typedef struct { logic [31:0] s; logic [15:0] n; } frm_t;
  pix_t pq[$];
  frm_t fq[$];
  pix_t mp;
  frm_t mf;
  int m_phs, m_pvs, m_hc, m_lc, m_hseen, m_vseen, m_lock, m_sf;
  logic [2:0]  m_err;
  logic [31:0] m_acc;
  logic [15:0] m_fc;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    m_phs = 0; m_pvs = 0; m_hc = 0; m_lc = 0; m_hseen = 0; m_vseen = 0;
    m_lock = 0; m_sf = 0; m_err = '0; m_acc = '0; m_fc = '0;
  endfunction
  // m_lock: 0 unlocked, 1 seeking, 2 locked
  function automatic void model(logic hs, logic vs, logic bl, logic [23:0] c, logic clr);
    bit hf = (m_phs == 1) && !hs;
    bit vf = (m_pvs == 1) && !vs;
    logic [2:0] ne = '0;
    bit act, pv;
    if (hf) begin
      if (m_hseen == 1 && m_hc + 1 != HT) ne[0] = 1'b1;
      m_hseen = 1;
    end
    m_hc = hf ? 0 : (m_hc < 1023 ? m_hc + 1 : 1023);
    if (vf) begin
      if (m_vseen == 1 && m_lc + int'(hf) != VT) ne[1] = 1'b1;
      m_vseen = 1;
    end
    m_lc = vf ? 0 : (hf ? (m_lc < 1023 ? m_lc + 1 : 1023) : m_lc);
    act = m_hc >= HS + HB && m_hc < HS + HB + HA && m_lc >= VS + VB && m_lc < VS + VB + VA;
    if (m_lock == 2 && bl != act) ne[2] = 1'b1;
    pv = m_lock == 2 && bl;
    if (pv) begin
      pq.push_back('{m_hc - (HS + HB), m_lc - (VS + VB), c});
      m_acc = m_acc + 32'(c[23:16]) + 32'(c[15:8]) + 32'(c[7:0]);
    end
    if (vf && m_lock == 2) begin
      m_fc = m_fc + 16'd1;
      fq.push_back('{m_acc, m_fc});
      m_acc = '0;
    end
    if (m_lock == 0) begin
      if (vf) begin m_lock = 1; m_sf = 0; end
    end else if (ne != 0) m_lock = 0;
    else if (m_lock == 1 && vf) begin
      m_sf++;
      if (m_sf == 2) m_lock = 2;
    end
    m_err = (clr ? 3'd0 : m_err) | ne;
    m_phs = int'(hs);
    m_pvs = int'(vs);
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid) begin
        if (pq.size() == 0) chk("pixel_valid_unexpected", 1, 0);
        else begin
          mp = pq.pop_front();
          chk("x_pos", 32'(x_pos), mp.x);
          chk("y_pos", 32'(y_pos), mp.y);
          chk("pixel_rgb", 32'(pixel_rgb), 32'(mp.c));
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) chk("frame_done_unexpected", 1, 0);
        else begin
          mf = fq.pop_front();
          chk("frame_sum", frame_sum, mf.s);
          chk("frame_count", 32'(frame_count), 32'(mf.n));
        end
      end
    end
  end
  task automatic pix(logic hs, logic vs, logic bl, logic [23:0] c, logic clr);
    @(negedge clk);
    err_clr = 1'b0;
    chk("locked", 32'(locked), 32'(m_lock == 2));
    chk("err_flags", 32'(err_flags), 32'(m_err));
    vga_clk = 1'b1; hsync = hs; vsync = vs; blank_n = bl; rgb = c;
    model(hs, vs, bl, c, clr);
    @(negedge clk);
    vga_clk = 1'b0;
    err_clr = clr;
  endtask
  task automatic reset_checks(string tag);
    chk({tag, "_x_pos"}, 32'(x_pos), 0);
    chk({tag, "_y_pos"}, 32'(y_pos), 0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_pixel_rgb"}, 32'(pixel_rgb), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_count"}, 32'(frame_count), 0);
    chk({tag, "_frame_sum"}, frame_sum, 0);
    chk({tag, "_err_flags"}, 32'(err_flags), 0);
  endtask
  task automatic mid_reset();
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic frame(int start_l, int nl, int short_l, int gl_l, int gl_h, int clr_l, int rst_l, bit cst);
    for (int l = start_l; l < nl; l++) begin
      if (l == rst_l) mid_reset();
      for (int h = 0; h < ((l == short_l) ? HT - 1 : HT); h++) begin
        bit act = h >= HS + HB && h < HS + HB + HA && l >= VS + VB && l < VS + VB + VA;
        pix(h >= HS, l >= VS, act && !(l == gl_l && h == gl_h),
            cst ? 24'h010203 : 24'($urandom), l == clr_l && h == 3);
      end
    end
  endtask
  task automatic clean(int n);
    for (int i = 0; i < n; i++) frame(0, VT, -1, -1, -1, -1, -1, 1'b0);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    frame(5, VT, -1, -1, -1, -1, -1, 1'b0);
    clean(4);
    chk("nominal_locked", 32'(locked), 1);
    chk("nominal_err", 32'(err_flags), 0);
    frame(0, VT, -1, -1, -1, -1, -1, 1'b1);
    clean(1);
    chk("const_frame_sum", frame_sum, 32'd288);
    frame(0, VT, 6, -1, -1, -1, -1, 1'b0);
    chk("short_line_unlock", 32'(locked), 0);
    chk("short_line_err", 32'(err_flags[0]), 1);
    frame(0, VT, -1, -1, -1, 0, -1, 1'b0);
    chk("short_line_cleared", 32'(err_flags), 0);
    clean(2);
    chk("short_line_relock", 32'(locked), 1);
    frame(0, VT, -1, 5, 9, -1, -1, 1'b0);
    chk("blank_err", 32'(err_flags), 32'd4);
    chk("blank_unlock", 32'(locked), 0);
    frame(0, VT, -1, -1, -1, 0, -1, 1'b0);
    clean(2);
    chk("blank_relock", 32'(locked), 1);
    frame(0, VT - 1, -1, -1, -1, -1, -1, 1'b0);
    clean(1);
    chk("frame_len_err", 32'(err_flags), 32'd2);
    frame(0, VT, -1, -1, -1, 0, -1, 1'b0);
    clean(2);
    frame(0, VT, -1, -1, -1, -1, 7, 1'b0);
    clean(3);
    chk("post_reset_err", 32'(err_flags), 0);
    chk("post_reset_locked", 32'(locked), 1);
    repeat (4) @(negedge clk);
    chk("pixel_queue_drained", pq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
